// File: rtl/axis_fifo_rr_arbiter.sv
// Round-robin arbiter that muxes NUM_PORTS AXI-Stream sources onto one FIFO write port.
// Latency: one registered arbitration cycle from request to grant, then data passes combinationally; one idle cycle after each release.
// Backpressure: m_axis_tready reaches only the granted source; a stalled sink holds the grant and consumes no beats.
// Ports: aclk / arstn (async, active-low); s_axis_* are packed per-port sources, port n in slice n;
//        m_axis_* is the muxed stream toward the FIFO; grant is the registered one-hot owner.
module axis_fifo_rr_arbiter #(
   parameter int NUM_PORTS   = 4,
   parameter int BUS_WIDTH   = 1,
   parameter int USER_WIDTH  = 1,
   parameter int DEST_WIDTH  = 1,
   parameter int PACKET_MODE = 1,
   parameter int MAX_BEATS   = 16
) (
   input  logic                              aclk,
   input  logic                              arstn,
   input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
   output logic [NUM_PORTS-1:0]              s_axis_tready,
   input  logic [NUM_PORTS*BUS_WIDTH*8-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*BUS_WIDTH-1:0]    s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]              s_axis_tlast,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_PORTS*DEST_WIDTH-1:0]   s_axis_tdest,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [BUS_WIDTH*8-1:0]            m_axis_tdata,
   output logic [BUS_WIDTH-1:0]              m_axis_tkeep,
   output logic                              m_axis_tlast,
   output logic [USER_WIDTH-1:0]             m_axis_tuser,
   output logic [DEST_WIDTH-1:0]             m_axis_tdest,
   output logic [NUM_PORTS-1:0]              grant
);

   // A zero budget would never release; treat it as one beat.
   localparam int MB = (MAX_BEATS < 1) ? 1 : MAX_BEATS;
   localparam int CW = $clog2(MB + 1);
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int DW = BUS_WIDTH * 8;

   typedef enum logic [0:0] {IDLE, XFER} state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        last_q, last_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 req_found;
   logic [IW-1:0]        req_idx;
   logic [IW:0]          cand_sum;
   logic                 sel_vld;
   logic                 sel_last;
   logic                 beat;
   logic                 rel;

   // Rotating priority search starting just after the previous owner.
   // last_q + k is below 2*NUM_PORTS, so one conditional subtract is a full modulo.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand_sum  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand_sum = {1'b0, last_q} + (IW+1)'(k);
         if (cand_sum >= (IW+1)'(NUM_PORTS)) begin
            cand_sum = cand_sum - (IW+1)'(NUM_PORTS);
         end
         if (!req_found && s_axis_tvalid[cand_sum[IW-1:0]]) begin
            req_found = 1'b1;
            req_idx   = cand_sum[IW-1:0];
         end
      end
   end

   // One-hot mux; with no grant every output field is zero.
   always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      m_axis_tuser = '0;
      m_axis_tdest = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant_q[p]) begin
            m_axis_tdata = s_axis_tdata[p*DW +: DW];
            m_axis_tkeep = s_axis_tkeep[p*BUS_WIDTH +: BUS_WIDTH];
            m_axis_tuser = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
            m_axis_tdest = s_axis_tdest[p*DEST_WIDTH +: DEST_WIDTH];
         end
      end
   end

   assign sel_vld       = |(s_axis_tvalid & grant_q);
   assign sel_last      = |(s_axis_tlast & grant_q);
   assign m_axis_tvalid = (state_q == XFER) && sel_vld;
   assign m_axis_tlast  = sel_last;
   assign s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
   assign grant         = grant_q;
   assign beat          = (state_q == XFER) && sel_vld && m_axis_tready;

   // Packet mode waits for tlast regardless of source gaps; stream mode
   // gives up the port on budget exhaustion or the first idle cycle.
   always_comb begin
      rel = 1'b0;
      if (PACKET_MODE != 0) begin
         rel = beat && sel_last;
      end else begin
         rel = (beat && (cnt_q == CW'(MB - 1))) || !sel_vld;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_found) begin
               state_d = XFER;
               grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << req_idx;
               gidx_d  = req_idx;
            end
         end
         XFER: begin
            if (beat && (cnt_q != CW'(MB))) begin
               cnt_d = cnt_q + CW'(1);
            end
            if (rel) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = gidx_q;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(NUM_PORTS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
`timescale 1ns/1ps
module tb_axis_fifo_rr_arbiter;
   localparam int NP     = 4;
   localparam int MBEATS = 16;

   logic            aclk  = 1'b0;
   logic            arstn = 1'b1;
   logic [NP-1:0]   s_tvalid = '0;
   logic [NP-1:0]   s_tlast  = '0;
   logic [NP-1:0]   s_tkeep  = '0;
   logic [NP-1:0]   s_tuser  = '0;
   logic [NP-1:0]   s_tdest  = '0;
   logic [NP*8-1:0] s_tdata  = '0;
   logic            m_rdy    = 1'b0;
   logic            sel      = 1'b0;   // 0: packet-mode DUT, 1: stream-mode DUT

   logic [NP-1:0] rdy0, rdy1, g0, g1;
   logic          mv0, mv1, mk0, mk1, ml0, ml1, mu0, mu1, mt0, mt1;
   logic [7:0]    md0, md1;
   logic          mr0, mr1;

   logic [NP-1:0] o_g, o_r;
   logic          o_v, o_k, o_l, o_u, o_t;
   logic [7:0]    o_d;

   always #5 aclk = ~aclk;

   assign mr0 = m_rdy & ~sel;
   assign mr1 = m_rdy & sel;
   assign o_g = sel ? g1 : g0;
   assign o_r = sel ? rdy1 : rdy0;
   assign o_v = sel ? mv1 : mv0;
   assign o_d = sel ? md1 : md0;
   assign o_k = sel ? mk1 : mk0;
   assign o_l = sel ? ml1 : ml0;
   assign o_u = sel ? mu1 : mu0;
   assign o_t = sel ? mt1 : mt0;

   axis_fifo_rr_arbiter #(.NUM_PORTS(NP), .BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1),
                          .PACKET_MODE(1), .MAX_BEATS(MBEATS)) u_pkt (
      .aclk(aclk), .arstn(arstn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy0), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .s_axis_tdest(s_tdest),
      .m_axis_tvalid(mv0), .m_axis_tready(mr0), .m_axis_tdata(md0), .m_axis_tkeep(mk0),
      .m_axis_tlast(ml0), .m_axis_tuser(mu0), .m_axis_tdest(mt0), .grant(g0));

   axis_fifo_rr_arbiter #(.NUM_PORTS(NP), .BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1),
                          .PACKET_MODE(0), .MAX_BEATS(MBEATS)) u_str (
      .aclk(aclk), .arstn(arstn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy1), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .s_axis_tdest(s_tdest),
      .m_axis_tvalid(mv1), .m_axis_tready(mr1), .m_axis_tdata(md1), .m_axis_tkeep(mk1),
      .m_axis_tlast(ml1), .m_axis_tuser(mu1), .m_axis_tdest(mt1), .grant(g1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Source streams: per-port beat memories {tlast, tdata}.
   logic [8:0] smem [NP][64];
   int         wp [NP];
   int         rp [NP];
   int         seq [NP];
   bit         src_en [NP];
   int         fire_port = -1;

   task automatic push_beats(input int p, input int len, input bit with_last);
      for (int i = 0; i < len; i++) begin
         smem[p][wp[p]] = {(with_last && (i == len - 1)), 8'((p << 6) | (seq[p] & 63))};
         wp[p]++;
         seq[p]++;
      end
   endtask

   task automatic drive_src();
      logic [8:0] h;
      for (int p = 0; p < NP; p++) begin
         h = (rp[p] < wp[p]) ? smem[p][rp[p]] : 9'd0;
         s_tvalid[p]        = src_en[p] && (rp[p] < wp[p]);
         s_tlast[p]         = h[8];
         s_tdata[p*8 +: 8]  = h[7:0];
         s_tkeep[p]         = h[0];
         s_tuser[p]         = h[1];
         s_tdest[p]         = h[6];
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
      if (fire_port >= 0) rp[fire_port]++;
      drive_src();
      #1;
   endtask

   // Reference model: owner index (-1 = nobody), previous owner, beats in current grant.
   int md_owner = -1;
   int md_last  = NP - 1;
   int md_cnt   = 0;

   function automatic int first_req(input int last, input logic [NP-1:0] v);
      int r;
      r = -1;
      for (int k = 1; k <= NP; k++) begin
         if (r < 0 && v[(last + k) % NP]) r = (last + k) % NP;
      end
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge aclk or negedge arstn);
         if (!arstn) begin
            md_owner = -1;
            md_last  = NP - 1;
            md_cnt   = 0;
         end else if (md_owner < 0) begin
            md_owner = first_req(md_last, s_tvalid);
            md_cnt   = 0;
         end else if (sel == 1'b0) begin
            if (s_tvalid[md_owner] && m_rdy && s_tlast[md_owner]) begin
               md_last  = md_owner;
               md_owner = -1;
            end
         end else begin
            if (!s_tvalid[md_owner] || (m_rdy && (md_cnt + 1 == MBEATS))) begin
               md_last  = md_owner;
               md_owner = -1;
               md_cnt   = 0;
            end else if (m_rdy) begin
               md_cnt = md_cnt + 1;
            end
         end
      end
   end

   // Per-cycle comparison plus logs of observed beats and grant sequence.
   logic [NP-1:0] e_g, e_r, prev_g;
   logic          e_v, e_k, e_l, e_u, e_t;
   logic [7:0]    e_d;
   logic [7:0]    blog [256];
   logic [NP-1:0] glog [64];
   int            nlog = 0;
   int            ng   = 0;

   initial begin
      prev_g = '0;
      forever begin
         @(negedge aclk);
         if (md_owner < 0) begin
            e_g = '0; e_r = '0; e_v = 1'b0; e_d = '0;
            e_k = 1'b0; e_l = 1'b0; e_u = 1'b0; e_t = 1'b0;
         end else begin
            e_g = 4'b0001 << md_owner;
            e_r = m_rdy ? e_g : '0;
            e_v = s_tvalid[md_owner];
            e_d = s_tdata[md_owner*8 +: 8];
            e_k = s_tkeep[md_owner];
            e_l = s_tlast[md_owner];
            e_u = s_tuser[md_owner];
            e_t = s_tdest[md_owner];
         end
         chk("grant", o_g, e_g);
         chk("s_tready", o_r, e_r);
         chk("m_tvalid", o_v, e_v);
         chk("m_tdata", o_d, e_d);
         chk("m_tkeep", o_k, e_k);
         chk("m_tlast", o_l, e_l);
         chk("m_tuser", o_u, e_u);
         chk("m_tdest", o_t, e_t);
         fire_port = (md_owner >= 0 && e_v && m_rdy && arstn) ? md_owner : -1;
         if (o_v && m_rdy && nlog < 256) begin
            blog[nlog] = o_d;
            nlog++;
         end
         if (o_g != '0 && o_g != prev_g && ng < 64) begin
            glog[ng] = o_g;
            ng++;
         end
         prev_g = o_g;
      end
   end

   task automatic do_reset(input logic s);
      arstn = 1'b0;
      sel   = s;
      m_rdy = 1'b1;
      for (int p = 0; p < NP; p++) begin
         wp[p] = 0; rp[p] = 0; seq[p] = 0; src_en[p] = 1'b0;
      end
      drive_src();
      #1;
      chk("rst_grant", o_g, 0);
      chk("rst_mvalid", o_v, 0);
      chk("rst_tready", o_r, 0);
      repeat (2) step();
      arstn = 1'b1;
      nlog  = 0;
      ng    = 0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      bit done;
      int n;
      done = 1'b0;
      n    = 0;
      while (!done && n < budget) begin
         step();
         n++;
         done = 1'b1;
         for (int p = 0; p < NP; p++) if (rp[p] < wp[p]) done = 1'b0;
         if (md_owner >= 0 || o_g != '0) done = 1'b0;
      end
      chk(nm, done, 1);
   endtask

   logic [7:0] exp_b;

   initial begin
      #1;
      // 1: single 4-beat packet on port 1
      do_reset(1'b0);
      push_beats(1, 4, 1'b1);
      src_en[1] = 1'b1;
      drive_src();
      step();
      chk("t1_grant", o_g, 4'b0010);
      repeat (3) step();
      chk("t1_lastdata", o_d, 8'h43);
      chk("t1_lastflag", o_l, 1);
      step();
      chk("t1_release", o_g, 4'b0000);
      wait_idle(50, "t1_drain");
      chk("t1_nbeats", nlog, 4);
      chk("t1_b0", blog[0], 8'h40);
      chk("t1_b3", blog[3], 8'h43);

      // 2: four ports, two 2-beat packets each, strict rotation
      do_reset(1'b0);
      for (int p = 0; p < NP; p++) begin
         push_beats(p, 2, 1'b1);
         push_beats(p, 2, 1'b1);
         src_en[p] = 1'b1;
      end
      drive_src();
      wait_idle(200, "t2_drain");
      chk("t2_ngrants", ng, 8);
      chk("t2_g0", glog[0], 4'b0001);
      chk("t2_g1", glog[1], 4'b0010);
      chk("t2_g2", glog[2], 4'b0100);
      chk("t2_g3", glog[3], 4'b1000);
      chk("t2_g4", glog[4], 4'b0001);
      chk("t2_b1", blog[1], 8'h01);
      chk("t2_b2", blog[2], 8'h40);
      chk("t2_b5", blog[5], 8'h81);
      chk("t2_b7", blog[7], 8'hC1);
      chk("t2_b8", blog[8], 8'h02);

      // 3: port 2 goes idle for 3 cycles mid-packet while port 3 waits
      do_reset(1'b0);
      push_beats(2, 4, 1'b1);
      push_beats(3, 2, 1'b1);
      src_en[2] = 1'b1;
      src_en[3] = 1'b1;
      drive_src();
      step();
      chk("t3_grant", o_g, 4'b0100);
      for (int i = 0; i < 20 && rp[2] < 2; i++) step();
      src_en[2] = 1'b0;
      drive_src();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold", o_g, 4'b0100);
         chk("t3_tready", o_r, 4'b0100);
         step();
      end
      src_en[2] = 1'b1;
      drive_src();
      wait_idle(50, "t3_drain");
      chk("t3_b2", blog[2], 8'h82);
      chk("t3_b3", blog[3], 8'h83);
      chk("t3_b4", blog[4], 8'hC0);

      // 5: sink stalls for 10 cycles mid-packet
      do_reset(1'b0);
      push_beats(0, 4, 1'b1);
      src_en[0] = 1'b1;
      drive_src();
      repeat (3) step();
      m_rdy = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("t5_valid", o_v, 1);
         chk("t5_data", o_d, 8'h02);
         step();
      end
      m_rdy = 1'b1;
      wait_idle(50, "t5_drain");
      chk("t5_nbeats", nlog, 4);
      chk("t5_b2", blog[2], 8'h02);
      chk("t5_b3", blog[3], 8'h03);

      // 6: reset during beat 2 of a port-1 packet
      do_reset(1'b0);
      push_beats(1, 4, 1'b1);
      src_en[1] = 1'b1;
      drive_src();
      repeat (2) step();
      chk("t6_beat2", o_d, 8'h41);
      arstn = 1'b0;
      #1;
      chk("t6_rst_grant", o_g, 0);
      chk("t6_rst_valid", o_v, 0);
      push_beats(0, 2, 1'b1);
      src_en[0] = 1'b1;
      drive_src();
      step();
      arstn = 1'b1;
      step();
      chk("t6_first", o_g, 4'b0001);
      wait_idle(50, "t6_drain");
      chk("t6_nbeats", nlog, 6);
      chk("t6_b1", blog[1], 8'h00);
      chk("t6_b3", blog[3], 8'h41);

      // 4: stream mode, 16-beat budget, ports 0 and 3 streaming
      do_reset(1'b1);
      push_beats(0, 40, 1'b0);
      push_beats(3, 20, 1'b0);
      src_en[0] = 1'b1;
      src_en[3] = 1'b1;
      drive_src();
      wait_idle(300, "t4_drain");
      chk("t4_nbeats", nlog, 60);
      chk("t4_g0", glog[0], 4'b0001);
      chk("t4_g1", glog[1], 4'b1000);
      chk("t4_g2", glog[2], 4'b0001);
      for (int i = 0; i < 48; i++) begin
         if (i < 16)      exp_b = 8'(i);
         else if (i < 32) exp_b = 8'(8'hC0 + i - 16);
         else             exp_b = 8'(8'h10 + i - 32);
         chk("t4_beat", blog[i], exp_b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
